// File: rtl/ebus_arbiter.sv
// ebus_arbiter: registered, handshaked ownership arbiter for the shared 36-bit EBUS.
// Ports: clk; resetN (async, active-low); req[NREQ] per-requester request, held for the tenure;
//   reqData[NREQ*36] requester i at [36*i+35:36*i]; grant one-hot registered grant;
//   EBUS[0:35] registered bus value; ebusValid; ebusOwner (valid with ebusValid);
//   timeoutErr one-cycle pulse when the hold watchdog ends a tenure.
// Build option EBUS_ARB_RR_EN: round-robin winner selection; undefined gives fixed priority (index 0 highest).
module ebus_arbiter #(
  parameter int NREQ = 7,
  parameter int MAXHOLD = 16
) (
  input  logic clk,
  input  logic resetN,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ*36-1:0] reqData,
  output logic [NREQ-1:0] grant,
  output logic [0:35] EBUS,
  output logic ebusValid,
  output logic [$clog2(NREQ)-1:0] ebusOwner,
  output logic timeoutErr
);
  localparam int OW = $clog2(NREQ);
  typedef enum logic [1:0] {IDLE, XFER, RECOVER} stateT;
  stateT state, stateNext;
  logic [7:0] holdCnt, holdNext;
  logic [NREQ-1:0] grantNext;
  logic [0:35] ebusNext;
  logic validNext, timeoutNext, hit;
  logic [OW-1:0] ownerNext, win, idx;
  logic [35:0] slot [NREQ];
`ifdef EBUS_ARB_RR_EN
  logic [OW-1:0] lastOwner, lastNext;
`endif
  always_comb
    for (int i = 0; i < NREQ; i++) slot[i] = reqData[36*i +: 36];
  // Winner search walks NREQ slots from the start index, wrapping at NREQ-1.
  always_comb begin
`ifdef EBUS_ARB_RR_EN
    idx = (lastOwner == OW'(NREQ-1)) ? '0 : lastOwner + OW'(1);
`else
    idx = '0;
`endif
    win = '0;
    hit = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!hit && req[idx]) begin
        win = idx;
        hit = 1'b1;
      end
      idx = (idx == OW'(NREQ-1)) ? '0 : idx + OW'(1);
    end
  end
  always_comb begin
    stateNext = state;
    grantNext = grant;
    ebusNext = EBUS;
    validNext = ebusValid;
    ownerNext = ebusOwner;
    holdNext = holdCnt;
    timeoutNext = 1'b0;
`ifdef EBUS_ARB_RR_EN
    lastNext = lastOwner;
`endif
    case (state)
      IDLE:
        if (hit) begin
          stateNext = XFER;
          grantNext = NREQ'(1) << win;
          ownerNext = win;
          holdNext = '0;
`ifdef EBUS_ARB_RR_EN
          lastNext = win;
`endif
        end
      XFER:
        // A dropped request outranks the watchdog, so no error on a simultaneous release.
        if (!req[ebusOwner] || holdCnt == 8'(MAXHOLD)) begin
          stateNext = RECOVER;
          grantNext = '0;
          ebusNext = '0;
          validNext = 1'b0;
          timeoutNext = req[ebusOwner];
        end else begin
          ebusNext = slot[ebusOwner];
          validNext = 1'b1;
          holdNext = holdCnt + 8'd1;
        end
      default: begin
        stateNext = IDLE;
        grantNext = '0;
        ebusNext = '0;
        validNext = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      state <= IDLE;
      grant <= '0;
      EBUS <= '0;
      ebusValid <= 1'b0;
      ebusOwner <= '0;
      timeoutErr <= 1'b0;
      holdCnt <= '0;
`ifdef EBUS_ARB_RR_EN
      lastOwner <= OW'(NREQ-1);
`endif
    end else begin
      state <= stateNext;
      grant <= grantNext;
      EBUS <= ebusNext;
      ebusValid <= validNext;
      ebusOwner <= ownerNext;
      timeoutErr <= timeoutNext;
      holdCnt <= holdNext;
`ifdef EBUS_ARB_RR_EN
      lastOwner <= lastNext;
`endif
    end
endmodule

// File: doc/ebus_arbiter.md
# ebus_arbiter

Arbitrates ownership of the shared 36-bit EBUS among the EBOX-internal drivers (APR, CRA, EDP, IR, SCD) and the external EBUS devices (RH20, DTE20). Replaces the ad-hoc priority chain of `XXXdrivingEBUS` signals with a registered, handshaked grant scheme. Owner tenure is bounded by a hold-time watchdog. A one-cycle turnaround separates successive owners. Sits at top level beside the EBOX, feeding the `EBUS` input of every EBUS client.

## Interface
- `NREQ`, 7, number of requesters; index 0..4 = APR, CRA, EDP, IR, SCD; 5 = RH20; 6 = DTE20.
- `MAXHOLD`, 16, maximum data-capture cycles per tenure; legal range 1..255.
- `clk`  in  1  sole clock.
- `resetN`  in  1  asynchronous, active-low reset.
- `req`  in  NREQ  per-requester bus request; held high for the whole tenure.
- `reqData`  in  NREQ*36  flattened requester data; requester i occupies bits [36*i+35:36*i].
- `grant`  out  NREQ  one-hot grant, registered.
- `EBUS`  out  [0:35]  registered bus value.
- `ebusValid`  out  1  EBUS carries owner data this cycle.
- `ebusOwner`  out  3  index of current owner; meaningful only while `ebusValid` = 1.
- `timeoutErr`  out  1  one-cycle pulse when a tenure is forcibly ended.

## Operation
- State machine states:
  - IDLE
    - If any `req` bit is high: select a winner (see Configuration), set `grant[winner]`, load `owner`, clear `holdCnt`, go to XFER.
    - Otherwise stay in IDLE.
  - XFER, evaluated in priority order at each edge:
    - (a) `req[owner]` = 0: clear `grant`, `EBUS` ← 0, `ebusValid` ← 0, go to RECOVER.
    - (b) `holdCnt` == MAXHOLD: clear `grant`, `EBUS` ← 0, `ebusValid` ← 0, pulse `timeoutErr`, go to RECOVER.
    - (c) Otherwise: `EBUS` ← `reqData[owner]`, `ebusValid` ← 1, `holdCnt`++.
  - RECOVER
    - Bus turnaround cycle.
    - Outputs stay at 0.
    - Go to IDLE unconditionally.
- Each tenure therefore delivers at most MAXHOLD captures.
- Case (a) wins over case (b): when the request drops on the same edge the limit is reached, `timeoutErr` is not pulsed.
- Requests that arrive during XFER or RECOVER wait; they are not lost as long as the request is held.
- A requester whose grant was revoked by timeout and who keeps `req` high re-competes in the next IDLE. It is not blacklisted.
- `holdCnt` width is 8 bits. It never wraps because it is bounded by MAXHOLD.
- Reset values: `grant` = 0, `EBUS` = 0, `ebusValid` = 0, `ebusOwner` = 0, `timeoutErr` = 0, state = IDLE, `holdCnt` = 0, `lastOwner` = NREQ-1.
- Reset asserted mid-tenure clears all outputs immediately, without waiting for a clock edge.

## Timing
- Edge E0: `req[i]` is sampled high in IDLE. After E0, `grant[i]` = 1.
- Edge E1: first capture. After E1, `EBUS` = `reqData[i]` as sampled at E1, and `ebusValid` = 1.
- Request-to-data latency is 2 edges.
- The requester drives valid data from the cycle after the grant.
- Release: `req[i]` is low at edge Ek. After Ek, `grant` = 0 and `ebusValid` = 0. After Ek+1 the state is IDLE. The earliest next grant is after Ek+2.
- There are at least 2 dead bus cycles between consecutive tenures.
- A requester holding `req` continuously gets exactly MAXHOLD valid cycles, then a `timeoutErr` pulse coincident with the first dead cycle.
- `grant` is never high for two requesters in the same cycle.
- `grant` is never high in RECOVER.

## Configuration
- `EBUS_ARB_RR_EN`
  - Defined: round-robin selection. The search starts at `lastOwner`+1, modulo NREQ. `lastOwner` is updated on every grant.
  - Undefined: fixed priority, lowest index wins. `lastOwner` is unused and may be optimized away.
  - All other behaviour is identical in both modes.

## Test plan
- Single requester: `req[2]` high for 3 data cycles with data 36'o123456701234 → `grant[2]` after E0; `EBUS` = 36'o123456701234 and `ebusValid` = 1 for 3 cycles; 2 dead cycles follow; `timeoutErr` stays 0.
- Timeout: `req[5]` held high indefinitely, MAXHOLD = 16 → exactly 16 `ebusValid` cycles; `timeoutErr` pulses once; `grant[5]` is re-asserted 2 edges later.
- Contention with `EBUS_ARB_RR_EN` defined: `req[0]`, `req[3]` and `req[6]` all held high, each releasing after 1 data cycle → grant order 0, 3, 6, 0.
- Contention with `EBUS_ARB_RR_EN` undefined, same stimulus → grant order 0, 0, 0; indices 3 and 6 are starved.
- Boundary: `req[1]` drops on the same edge `holdCnt` reaches MAXHOLD → normal release with no `timeoutErr`; after that edge `ebusValid` = 0.
- Reset: `resetN` pulled low mid-XFER, between clock edges → `grant`, `EBUS` and `ebusValid` read 0 before the next edge. After release with `req[4]` high, the first grant goes to 4 after the first edge.
